// File: rtl/pmem_line_arbiter.sv
// Arbitrates I-cache and D-cache line requests onto one 4-beat pmem burst port.
// Define PMEM_ARB_RR_EN for round-robin grant; otherwise the D-cache has fixed priority.
module pmem_line_arbiter #(
  parameter int ADDR_W = 32,
  parameter int LINE_W = 256,
  parameter int BEAT_W = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_line_read,
  input  logic [ADDR_W-1:0] i_line_addr,
  output logic [LINE_W-1:0] i_line_rdata,
  output logic              i_line_resp,
  input  logic              d_line_read,
  input  logic              d_line_write,
  input  logic [ADDR_W-1:0] d_line_addr,
  input  logic [LINE_W-1:0] d_line_wdata,
  output logic [LINE_W-1:0] d_line_rdata,
  output logic              d_line_resp,
  output logic              pmem_read,
  output logic              pmem_write,
  output logic [ADDR_W-1:0] pmem_addr,
  output logic [BEAT_W-1:0] pmem_wdata,
  input  logic [BEAT_W-1:0] pmem_rdata,
  input  logic              pmem_resp
);
  localparam int BEATS = LINE_W / BEAT_W;
  localparam int CNT_W = $clog2(BEATS);
  localparam int OFF_W = $clog2(LINE_W / 8);

  typedef enum logic [2:0] {IDLE, I_RD, D_RD, D_WR, DONE} state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [LINE_W-1:0] wline_q, wline_d;
  logic [LINE_W-1:0] rbuf_q, rbuf_d;
  logic              i_resp_q, i_resp_d;
  logic              d_resp_q, d_resp_d;
  logic              d_req, pick_d;
`ifdef PMEM_ARB_RR_EN
  logic              last_d_q, last_d_d;
`endif

  assign d_req = d_line_read | d_line_write;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    addr_d   = addr_q;
    wline_d  = wline_q;
    rbuf_d   = rbuf_q;
    i_resp_d = 1'b0;
    d_resp_d = 1'b0;
    pick_d   = 1'b0;
`ifdef PMEM_ARB_RR_EN
    last_d_d = last_d_q;
`endif
    case (state_q)
      IDLE: begin
        cnt_d = '0;
`ifdef PMEM_ARB_RR_EN
        // on contention, the side that was not served last goes first
        pick_d = d_req && (!i_line_read || !last_d_q);
`else
        pick_d = d_req;
`endif
        if (pick_d) begin
          addr_d  = {d_line_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
          state_d = d_line_write ? D_WR : D_RD;
          if (d_line_write) wline_d = d_line_wdata;
        end else if (i_line_read) begin
          addr_d  = {i_line_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
          state_d = I_RD;
        end
      end
      I_RD, D_RD, D_WR: begin
        if (pmem_resp) begin
          cnt_d = cnt_q + 1'b1;
          if (state_q != D_WR) rbuf_d[cnt_q*BEAT_W +: BEAT_W] = pmem_rdata;
          if (cnt_q == CNT_W'(BEATS-1)) begin
            state_d  = DONE;
            i_resp_d = (state_q == I_RD);
            d_resp_d = (state_q != I_RD);
          end
        end
      end
      DONE: begin
        state_d = IDLE;
`ifdef PMEM_ARB_RR_EN
        last_d_d = d_resp_q;
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      addr_q   <= '0;
      wline_q  <= '0;
      rbuf_q   <= '0;
      i_resp_q <= 1'b0;
      d_resp_q <= 1'b0;
`ifdef PMEM_ARB_RR_EN
      last_d_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      addr_q   <= addr_d;
      wline_q  <= wline_d;
      rbuf_q   <= rbuf_d;
      i_resp_q <= i_resp_d;
      d_resp_q <= d_resp_d;
`ifdef PMEM_ARB_RR_EN
      last_d_q <= last_d_d;
`endif
    end
  end

  assign pmem_read    = (state_q == I_RD) || (state_q == D_RD);
  assign pmem_write   = (state_q == D_WR);
  assign pmem_addr    = addr_q;
  assign pmem_wdata   = wline_q[cnt_q*BEAT_W +: BEAT_W];
  assign i_line_rdata = rbuf_q;
  assign d_line_rdata = rbuf_q;
  assign i_line_resp  = i_resp_q;
  assign d_line_resp  = d_resp_q;
endmodule

// File: tb/tb_pmem_line_arbiter.sv
// Directed bench for pmem_line_arbiter with a wait-state-configurable burst memory model.
module tb_pmem_line_arbiter;
  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         i_line_read = 1'b0;
  logic [31:0]  i_line_addr = '0;
  logic [255:0] i_line_rdata;
  logic         i_line_resp;
  logic         d_line_read = 1'b0;
  logic         d_line_write = 1'b0;
  logic [31:0]  d_line_addr = '0;
  logic [255:0] d_line_wdata = '0;
  logic [255:0] d_line_rdata;
  logic         d_line_resp;
  logic         pmem_read, pmem_write;
  logic [31:0]  pmem_addr;
  logic [63:0]  pmem_wdata;
  logic [63:0]  pmem_rdata = '0;
  logic         pmem_resp = 1'b0;

  pmem_line_arbiter dut (
    .clk(clk), .rst(rst),
    .i_line_read(i_line_read), .i_line_addr(i_line_addr),
    .i_line_rdata(i_line_rdata), .i_line_resp(i_line_resp),
    .d_line_read(d_line_read), .d_line_write(d_line_write),
    .d_line_addr(d_line_addr), .d_line_wdata(d_line_wdata),
    .d_line_rdata(d_line_rdata), .d_line_resp(d_line_resp),
    .pmem_read(pmem_read), .pmem_write(pmem_write), .pmem_addr(pmem_addr),
    .pmem_wdata(pmem_wdata), .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_chk++;
    if (got !== exp) $display("FAIL %s got=%h exp=%h", tag, got, exp);
    else n_pass++;
  endtask

  // memory model: unwritten words read back as {addr, ~addr}
  logic [63:0]  mem [logic [31:0]];
  int           mwait = 0;
  int           mbeat = 0;
  int           wcnt = 0;
  int           wd_err = 0;
  logic [255:0] wexp = '0;

  function automatic logic [63:0] pat(input logic [31:0] a);
    return {a, ~a};
  endfunction

  function automatic logic [63:0] mem_rd(input logic [31:0] a);
    return mem.exists(a) ? mem[a] : pat(a);
  endfunction

  function automatic logic [255:0] exp_line(input logic [31:0] b);
    return {pat(b + 32'd24), pat(b + 32'd16), pat(b + 32'd8), pat(b)};
  endfunction

  function automatic logic [255:0] mem_line(input logic [31:0] b);
    return {mem_rd(b + 32'd24), mem_rd(b + 32'd16), mem_rd(b + 32'd8), mem_rd(b)};
  endfunction

  // responses are set up on the falling edge for the next rising edge
  always @(negedge clk) begin
    if (!rst || !(pmem_read || pmem_write)) begin
      pmem_resp = 1'b0;
      mbeat = 0;
      wcnt = 0;
    end else if (mbeat >= 4) begin
      pmem_resp = 1'b0;
    end else begin
      if (pmem_write && pmem_wdata !== wexp[mbeat*64 +: 64]) wd_err++;
      if (wcnt < mwait) begin
        pmem_resp = 1'b0;
        wcnt++;
      end else begin
        pmem_resp = 1'b1;
        wcnt = 0;
        if (pmem_write) mem[pmem_addr + 32'(8*mbeat)] = pmem_wdata;
        else pmem_rdata = mem_rd(pmem_addr + 32'(8*mbeat));
        mbeat++;
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // src: 0 I read, 1 D read, 2 D write, 3 D read+write together
  task automatic do_req(input int src, input logic [31:0] a, input logic [255:0] wl, input int wt,
                        output int lat, output logic [31:0] paddr, output bit srd, output bit swr,
                        output bit oth, output bit rafter, output logic [255:0] rline);
    mwait = wt;
    wexp = wl;
    if (src == 0) begin
      i_line_read = 1'b1;
      i_line_addr = a;
    end else begin
      d_line_read  = (src == 1 || src == 3);
      d_line_write = (src == 2 || src == 3);
      d_line_addr  = a;
      d_line_wdata = wl;
    end
    lat = -1; paddr = '0; srd = 0; swr = 0; oth = 0; rline = '0;
    for (int c = 1; c <= 100; c++) begin
      tick;
      if (pmem_read) srd = 1;
      if (pmem_write) swr = 1;
      if (pmem_read || pmem_write) paddr = pmem_addr;
      if (src == 0 ? d_line_resp : i_line_resp) oth = 1;
      if (src == 0 ? i_line_resp : d_line_resp) begin
        lat = c;
        rline = (src == 0) ? i_line_rdata : d_line_rdata;
        break;
      end
    end
    tick;
    i_line_read = 1'b0;
    d_line_read = 1'b0;
    d_line_write = 1'b0;
    rafter = i_line_resp | d_line_resp;
  endtask

  int           lat;
  logic [31:0]  paddr;
  bit           srd, swr, oth, rafter;
  logic [255:0] rline, wl;
  int           order [$];
  logic [255:0] iline, dline;
  bit           ip, dp, idone, ddone, bad_resp;
  int           exp_first;

  initial begin
`ifdef PMEM_ARB_RR_EN
    exp_first = 0;
`else
    exp_first = 1;
`endif
    // reset state
    #12;
    chk("rst_strobes", 256'({pmem_read, pmem_write, i_line_resp, d_line_resp}), 256'(0));
    chk("rst_addr", 256'(pmem_addr), 256'(0));
    chk("rst_wdata", 256'(pmem_wdata), 256'(0));
    chk("rst_irdata", i_line_rdata, 256'(0));
    chk("rst_drdata", d_line_rdata, 256'(0));
    rst = 1'b1;
    tick;

    // I read, zero wait states: resp in the 6th cycle counting the request cycle as the 1st
    mem[32'h1220] = 64'h1111_1111_1111_1111;
    mem[32'h1228] = 64'h2222_2222_2222_2222;
    mem[32'h1230] = 64'h3333_3333_3333_3333;
    mem[32'h1238] = 64'h4444_4444_4444_4444;
    do_req(0, 32'h0000_1234, '0, 0, lat, paddr, srd, swr, oth, rafter, rline);
    chk("i_lat", 256'(lat), 256'(5));
    chk("i_paddr", 256'(paddr), 256'(32'h0000_1220));
    chk("i_data", rline, {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
                          64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111});
    chk("i_no_write", 256'(swr), 256'(0));
    chk("i_no_dresp", 256'(oth), 256'(0));
    chk("i_resp_pulse", 256'(rafter), 256'(0));

    // D write with 2 wait cycles before every beat: 1 + 4*3 edges to DONE
    wl = {64'hDEAD_BEEF_0000_0003, 64'hDEAD_BEEF_0000_0002,
          64'hDEAD_BEEF_0000_0001, 64'hDEAD_BEEF_0000_0000};
    wd_err = 0;
    do_req(2, 32'h0000_2040, wl, 2, lat, paddr, srd, swr, oth, rafter, rline);
    chk("w_lat", 256'(lat), 256'(13));
    chk("w_paddr", 256'(paddr), 256'(32'h0000_2040));
    chk("w_no_read", 256'({srd, swr}), 256'(2'b01));
    chk("w_mem", mem_line(32'h0000_2040), wl);
    chk("w_wdata_hold", 256'(wd_err), 256'(0));
    chk("w_resp_pulse", 256'({rafter, oth}), 256'(0));

    // simultaneous I and D reads; last grant was D
    mwait = 0;
    order.delete();
    ip = 0; dp = 0; idone = 0; ddone = 0;
    i_line_read = 1'b1; i_line_addr = 32'h0000_1000;
    d_line_read = 1'b1; d_line_addr = 32'h0000_3000;
    for (int c = 0; c < 100 && !(idone && ddone); c++) begin
      tick;
      if (ip) begin i_line_read = 1'b0; ip = 0; end
      if (dp) begin d_line_read = 1'b0; dp = 0; end
      if (i_line_resp) begin ip = 1; idone = 1; iline = i_line_rdata; order.push_back(0); end
      if (d_line_resp) begin dp = 1; ddone = 1; dline = d_line_rdata; order.push_back(1); end
    end
    tick;
    i_line_read = 1'b0;
    d_line_read = 1'b0;
    chk("arb_count", 256'(order.size()), 256'(2));
    if (order.size() == 2) begin
      chk("arb_first", 256'(order[0]), 256'(exp_first));
      chk("arb_second", 256'(order[1]), 256'(1 - exp_first));
    end
    chk("arb_idata", iline, exp_line(32'h0000_1000));
    chk("arb_ddata", dline, exp_line(32'h0000_3000));

    // read and write together: write wins, no read strobe
    wl = {64'hA5A5_0000_0000_0004, 64'hA5A5_0000_0000_0003,
          64'hA5A5_0000_0000_0002, 64'hA5A5_0000_0000_0001};
    wd_err = 0;
    do_req(3, 32'h0000_4008, wl, 1, lat, paddr, srd, swr, oth, rafter, rline);
    chk("rw_strobes", 256'({srd, swr}), 256'(2'b01));
    chk("rw_paddr", 256'(paddr), 256'(32'h0000_4000));
    chk("rw_mem", mem_line(32'h0000_4000), wl);
    chk("rw_lat", 256'(lat), 256'(9));

    // reset after two beats of a read
    mwait = 0;
    i_line_read = 1'b1; i_line_addr = 32'h0000_5000;
    tick; tick; tick;
    chk("mid_read_active", 256'(pmem_read), 256'(1));
    #2 rst = 1'b0;
    #1;
    chk("rst_read_drop", 256'({pmem_read, pmem_write}), 256'(0));
    chk("rst_outs_zero", 256'({pmem_addr, pmem_wdata}), 256'(0));
    chk("rst_buf_zero", i_line_rdata, 256'(0));
    i_line_read = 1'b0;
    bad_resp = 0;
    tick; if (i_line_resp || d_line_resp) bad_resp = 1;
    tick; if (i_line_resp || d_line_resp) bad_resp = 1;
    rst = 1'b1;
    for (int c = 0; c < 8; c++) begin
      tick;
      if (i_line_resp || d_line_resp || pmem_read || pmem_write) bad_resp = 1;
    end
    chk("rst_no_resp", 256'(bad_resp), 256'(0));
    do_req(0, 32'h0000_6010, '0, 0, lat, paddr, srd, swr, oth, rafter, rline);
    chk("post_rst_lat", 256'(lat), 256'(5));
    chk("post_rst_data", rline, exp_line(32'h0000_6000));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
